// File: rtl/ula_seq.sv
// ula_seq: sequential WIDTH-bit ALU (ADD/SUB/SHL/SHR/AND/OR/XOR/NOT) with
// valid/ready handshakes on request and result, registered result and flags.
// Shifts are iterative (one bit per cycle) by default; defining
// ULA_BARREL_SHIFT_EN swaps in a single-cycle barrel shifter and drops the
// SHIFT state entirely.
module ula_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v
);

    localparam int CNT_W = $clog2(WIDTH + 2);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_SHL = 3'd2;
    localparam logic [2:0] OP_SHR = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;
    localparam logic [2:0] OP_XOR = 3'd6;
    localparam logic [2:0] OP_NOT = 3'd7;

`ifdef ULA_BARREL_SHIFT_EN
    typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
`endif

    state_t            state;
    logic              accept;
    logic              go_shift;
    logic [WIDTH:0]    ext;
    logic [WIDTH-1:0]  alu_res;
    logic              alu_c;
    logic              alu_v;

    // DONE only frees the slot when the consumer drains it this cycle
    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;

    // single-cycle result for everything that does not need the iterative shifter
    always_comb begin
        ext     = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op)
            OP_ADD: begin
                ext     = {1'b0, a} + {1'b0, b};
                alu_res = ext[WIDTH-1:0];
                alu_c   = ext[WIDTH];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                // bit WIDTH of the extended difference is the borrow (a < b)
                ext     = {1'b0, a} - {1'b0, b};
                alu_res = ext[WIDTH-1:0];
                alu_c   = ext[WIDTH];
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (ext[WIDTH-1] != a[WIDTH-1]);
            end
`ifdef ULA_BARREL_SHIFT_EN
            // one spare bit on the outgoing side catches the last bit shifted out
            OP_SHL: begin
                ext     = {1'b0, a} << b;
                alu_res = ext[WIDTH-1:0];
                alu_c   = ext[WIDTH];
            end
            OP_SHR: begin
                ext     = {a, 1'b0} >> b;
                alu_res = ext[WIDTH:1];
                alu_c   = ext[0];
            end
`else
            // only reached with b == 0: nothing moves, nothing shifted out
            OP_SHL:  alu_res = a;
            OP_SHR:  alu_res = a;
`endif
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_NOT:  alu_res = ~a;
            default: alu_res = '0;
        endcase
    end

`ifdef ULA_BARREL_SHIFT_EN
    assign go_shift = 1'b0;
`else
    logic [WIDTH-1:0] work;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_load;
    logic             dir_r;
    logic [WIDTH-1:0] work_nxt;
    logic             shout;

    assign go_shift = ((op == OP_SHL) || (op == OP_SHR)) && (b != '0);

    // more than WIDTH+1 steps cannot change anything: result and carry are both 0 by then
    assign cnt_load = ({1'b0, b} > (WIDTH + 1)'(WIDTH + 1)) ? CNT_W'(WIDTH + 1) : CNT_W'(b);

    // one-bit step of the working register; dir_r=1 is a right shift
    always_comb begin
        work_nxt = dir_r ? {1'b0, work[WIDTH-1:1]} : {work[WIDTH-2:0], 1'b0};
        shout    = dir_r ? work[0] : work[WIDTH-1];
    end
`endif

    // FSM, result and flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            result <= '0;
            flag_z <= 1'b0;
            flag_n <= 1'b0;
            flag_c <= 1'b0;
            flag_v <= 1'b0;
`ifndef ULA_BARREL_SHIFT_EN
            work   <= '0;
            cnt    <= '0;
            dir_r  <= 1'b0;
`endif
        end else if (accept) begin
            if (go_shift) begin
`ifndef ULA_BARREL_SHIFT_EN
                state <= SHIFT;
                work  <= a;
                cnt   <= cnt_load;
                dir_r <= op[0];
`endif
            end else begin
                state  <= DONE;
                result <= alu_res;
                flag_z <= (alu_res == '0);
                flag_n <= alu_res[WIDTH-1];
                flag_c <= alu_c;
                flag_v <= alu_v;
            end
        end else if ((state == DONE) && out_ready) begin
            state <= IDLE;
        end
`ifndef ULA_BARREL_SHIFT_EN
        else if (state == SHIFT) begin
            work <= work_nxt;
            cnt  <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
                state  <= DONE;
                result <= work_nxt;
                flag_z <= (work_nxt == '0);
                flag_n <= work_nxt[WIDTH-1];
                flag_c <= shout;
                flag_v <= 1'b0;
            end
        end
`endif
    end

endmodule

// File: tb/tb_ula_seq.sv
// tb_ula_seq: directed vectors for ula_seq at WIDTH=4, hand-computed expectations.
module tb_ula_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] op = 3'd0;
    logic [3:0] a = 4'd0;
    logic [3:0] b = 4'd0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] result;
    logic       flag_z, flag_n, flag_c, flag_v;

    int total = 0;
    int bad = 0;

`ifdef ULA_BARREL_SHIFT_EN
    localparam bit BARREL = 1'b1;
`else
    localparam bit BARREL = 1'b0;
`endif

    ula_seq #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result),
        .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // issue one request from IDLE, wait for the result, check it, then drain it
    task automatic run_op(input string tag, input logic [2:0] o, input logic [3:0] aa,
                          input logic [3:0] bb, input logic [3:0] er, input logic ec,
                          input logic ev, input logic ez, input logic en,
                          input int elat, input int estall);
        int lat;
        int stall;
        lat = 0;
        stall = 0;
        chk({tag, ".rdy"}, in_ready, 1);
        in_valid = 1'b1; op = o; a = aa; b = bb;
        while (1) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            // inputs wiggle after accept; they must have no effect
            a = ~aa; b = ~bb; op = ~o;
            lat++;
            if (out_valid) break;
            if (!in_ready) stall++;
            if (lat > 20) break;
        end
        chk({tag, ".lat"}, lat, elat);
        chk({tag, ".stall"}, stall, estall);
        chk({tag, ".res"}, result, er);
        chk({tag, ".c"}, flag_c, ec);
        chk({tag, ".v"}, flag_v, ev);
        chk({tag, ".z"}, flag_z, ez);
        chk({tag, ".n"}, flag_n, en);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, ".drain"}, out_valid, 0);
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst.ov", out_valid, 0);
        chk("rst.res", result, 0);
        chk("rst.flags", {flag_z, flag_n, flag_c, flag_v}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst.rdy", in_ready, 1);

        //      tag      op    a      b      res    c  v  z  n  lat stall
        run_op("add",   3'd0, 4'd9,  4'd8,  4'd1,  1, 1, 0, 0, 1, 0);
        run_op("sub",   3'd1, 4'd3,  4'd5,  4'd14, 1, 0, 0, 1, 1, 0);
        run_op("sub0",  3'd1, 4'd5,  4'd5,  4'd0,  0, 0, 1, 0, 1, 0);
        run_op("subv",  3'd1, 4'd8,  4'd1,  4'd7,  0, 1, 0, 0, 1, 0);
        run_op("or",    3'd5, 4'hA,  4'h5,  4'hF,  0, 0, 0, 1, 1, 0);
        run_op("not",   3'd7, 4'h6,  4'h0,  4'h9,  0, 0, 0, 1, 1, 0);
        run_op("shlb0", 3'd2, 4'h5,  4'd0,  4'h5,  0, 0, 0, 0, 1, 0);
        run_op("shl2",  3'd2, 4'h3,  4'd2,  4'hC,  0, 0, 0, 1, BARREL ? 1 : 3, BARREL ? 0 : 2);
        run_op("shl1",  3'd2, 4'h9,  4'd1,  4'h2,  1, 0, 0, 0, BARREL ? 1 : 2, BARREL ? 0 : 1);
        run_op("shr1",  3'd3, 4'h6,  4'd1,  4'h3,  0, 0, 0, 0, BARREL ? 1 : 2, BARREL ? 0 : 1);
        run_op("shr4",  3'd3, 4'hB,  4'd4,  4'h0,  1, 0, 1, 0, BARREL ? 1 : 5, BARREL ? 0 : 4);
        run_op("shr15", 3'd3, 4'hB,  4'd15, 4'h0,  0, 0, 1, 0, BARREL ? 1 : 6, BARREL ? 0 : 5);

        // backpressure: XOR result must hold while out_ready is low
        in_valid = 1'b1; op = 3'd6; a = 4'hA; b = 4'h6;
        @(posedge clk); #1;
        op = 3'd4; a = 4'hC; b = 4'hA;   // pending AND, not yet accepted
        for (int i = 0; i < 5; i++) begin
            chk("bp.ov", out_valid, 1);
            chk("bp.res", result, 4'hC);
            chk("bp.rdy", in_ready, 0);
            @(posedge clk); #1;
        end
        chk("bp.held", result, 4'hC);
        out_ready = 1'b1;
        #1;
        chk("bp.rdy1", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("and.ov", out_valid, 1);
        chk("and.res", result, 4'h8);
        chk("and.n", flag_n, 1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("and.drain", out_valid, 0);

        // reset during the second SHIFT cycle
        in_valid = 1'b1; op = 3'd2; a = 4'h1; b = 4'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mrst.ov", out_valid, 0);
        chk("mrst.res", result, 0);
        chk("mrst.flags", {flag_z, flag_n, flag_c, flag_v}, 0);
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("mrst.stale", out_valid, 0);
            chk("mrst.rdy", in_ready, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
